seg7_scan_driver: RTL and testbench

Downstream display stage for the 16-bit LED counter. Takes the counter value with a load strobe and shows it as four hexadecimal digits on a multiplexed common-anode seven-segment display. Digit scanning, anti-ghost guard interval, leading-zero blanking and tear-free frame-synchronous updates are handled internally. Runs in the `Sys_Clk0` domain beside the counter.

---
 rtl/seg7_pkg.sv | 15 +
 rtl/seg7_hex_decode.sv | 13 +
 rtl/seg7_scan_driver.sv | 141 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned NDIG = 4;

  // Glyphs indexed by nibble value, segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0]      SEG_OFF_AH = '0;
  localparam logic [NDIG-1:0] AN_OFF_AH  = '0;

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-high seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = HEX_GLYPH[nib];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit hex scan driver: shadow/display double buffer, frame-synchronous
// update, guard interval, leading-zero blanking and registered pins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 2000,
  parameter int unsigned GUARD       = 16,
  parameter int unsigned BLANK_LZ    = 1,
  parameter int unsigned SEG_ACT_LOW = 1,
  parameter int unsigned AN_ACT_LOW  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     value,
  input  logic            load,
  input  logic [3:0]      dp_in,
  output logic [6:0]      seg,
  output logic            dp,
  output logic [NDIG-1:0] an,
  output logic            upd
);

  localparam logic [15:0]     PCNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0]     GUARD_END = 16'(GUARD);
  localparam logic [6:0]      SEG_IDLE  = (SEG_ACT_LOW != 0) ? ~SEG_OFF_AH : SEG_OFF_AH;
  localparam logic            DP_IDLE   = (SEG_ACT_LOW != 0);
  localparam logic [NDIG-1:0] AN_IDLE   = (AN_ACT_LOW != 0) ? ~AN_OFF_AH : AN_OFF_AH;

  logic [15:0]     pcnt_q, pcnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [15:0]     shd_val_q, shd_val_d;
  logic [3:0]      shd_dp_q, shd_dp_d;
  logic [15:0]     disp_val_q, disp_val_d;
  logic [3:0]      disp_dp_q, disp_dp_d;
  logic            upd_q, upd_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [NDIG-1:0] an_q, an_d;

  logic            slot_end;
  logic            frame_end;
  logic            in_guard;
  logic            lz;
  logic [3:0]      nib;
  logic [6:0]      glyph;
  logic [6:0]      seg_ah;
  logic            dp_ah;
  logic [NDIG-1:0] an_ah;

  seg7_hex_decode u_dec (
    .nib   (nib),
    .glyph (glyph)
  );

  always_comb begin
    slot_end  = (pcnt_q == PCNT_LAST);
    frame_end = slot_end && (idx_q == 2'd3);
    in_guard  = (pcnt_q < GUARD_END);

    pcnt_d = slot_end ? '0 : pcnt_q + 16'd1;
    idx_d  = slot_end ? idx_q + 2'd1 : idx_q;

    // Boundary consumes the old shadow; a coincident load re-arms pend.
    shd_val_d  = shd_val_q;
    shd_dp_d   = shd_dp_q;
    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    pend_d     = pend_q;
    upd_d      = frame_end && pend_q;
    if (frame_end && pend_q) begin
      disp_val_d = shd_val_q;
      disp_dp_d  = shd_dp_q;
      pend_d     = 1'b0;
    end
    if (load) begin
      shd_val_d = value;
      shd_dp_d  = dp_in;
      pend_d    = 1'b1;
    end
  end

  always_comb begin
    nib = disp_val_q[3:0];
    lz  = 1'b0;
    unique case (idx_q)
      2'd0: begin nib = disp_val_q[3:0];   lz = 1'b0;                      end
      2'd1: begin nib = disp_val_q[7:4];   lz = (disp_val_q[15:4]  == '0); end
      2'd2: begin nib = disp_val_q[11:8];  lz = (disp_val_q[15:8]  == '0); end
      2'd3: begin nib = disp_val_q[15:12]; lz = (disp_val_q[15:12] == '0); end
      default: begin nib = disp_val_q[3:0]; lz = 1'b0; end
    endcase

    seg_ah = SEG_OFF_AH;
    an_ah  = AN_OFF_AH;
    dp_ah  = 1'b0;
    if (!in_guard) begin
      an_ah  = 4'b0001 << idx_q;
      dp_ah  = disp_dp_q[idx_q];
      seg_ah = ((BLANK_LZ != 0) && lz) ? SEG_OFF_AH : glyph;
    end

    seg_d = (SEG_ACT_LOW != 0) ? ~seg_ah : seg_ah;
    dp_d  = (SEG_ACT_LOW != 0) ? ~dp_ah  : dp_ah;
    an_d  = (AN_ACT_LOW  != 0) ? ~an_ah  : an_ah;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q     <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      shd_val_q  <= '0;
      shd_dp_q   <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      upd_q      <= 1'b0;
      seg_q      <= SEG_IDLE;
      dp_q       <= DP_IDLE;
      an_q       <= AN_IDLE;
    end else begin
      pcnt_q     <= pcnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      shd_val_q  <= shd_val_d;
      shd_dp_q   <= shd_dp_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      upd_q      <= upd_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;
  assign upd = upd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=8, GUARD=2.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        upd;

  seg7_scan_driver #(
    .SCAN_DIV    (8),
    .GUARD       (2),
    .BLANK_LZ    (1),
    .SEG_ACT_LOW (1),
    .AN_ACT_LOW  (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .dp_in (dp_in),
    .seg   (seg),
    .dp    (dp),
    .an    (an),
    .upd   (upd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t       slot_q[$];
  int unsigned upd_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  int unsigned cyc;

  // Edges since the last reset release; slot s is active on samples 8s+3..8s+8.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  // Pin-level expectations for the first nslots digits of one frame.
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpm, input int unsigned nslots);
    logic [3:0] an_pin [4];
    logic [6:0] seg_pin [4];
    slot_t e;
    an_pin[0] = 4'hE; an_pin[1] = 4'hD; an_pin[2] = 4'hB; an_pin[3] = 4'h7;
    seg_pin[0] = s0; seg_pin[1] = s1; seg_pin[2] = s2; seg_pin[3] = s3;
    for (int unsigned k = 0; k < nslots; k++) begin
      e.an  = an_pin[k];
      e.seg = seg_pin[k];
      e.dp  = ~dpm[k];
      slot_q.push_back(e);
    end
  endtask

  task automatic load_at(input int unsigned e, input logic [15:0] v, input logic [3:0] d);
    while (cyc != e - 1) @(negedge clk);
    value = v;
    dp_in = d;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic reset_pulse_at(input int unsigned e);
    while (cyc < e) begin
      @(posedge clk);
      #2;
    end
    rst = 1'b1;
    #1;
    check("rst_an",  32'(an),  32'h0000000F);
    check("rst_seg", 32'(seg), 32'h0000007F);
    check("rst_dp",  32'(dp),  32'h00000001);
    check("rst_upd", 32'(upd), 32'h00000000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: pops one slot expectation per active anode run, one cycle per upd pulse.
  slot_t       cur;
  bit          in_slot = 1'b0;
  int unsigned run = 0;

  always @(negedge clk) begin
    if (rst) begin
      in_slot = 1'b0;
    end else begin
      if (an != 4'hF) begin
        if (!in_slot) begin
          in_slot = 1'b1;
          run     = 0;
          check("slot_expected", 32'(slot_q.size() != 0), 32'd1);
          if (slot_q.size() != 0) cur = slot_q.pop_front();
          else                    cur = '0;
          check("slot_start_phase", 32'(cyc % 8), 32'd3);
        end
        run++;
        check("slot_pins", 32'({an, seg, dp}), 32'(cur));
      end else begin
        check("guard_off", 32'({seg, dp}), 32'h000000FF);
        if (in_slot) begin
          check("slot_len", 32'(run), 32'd6);
          in_slot = 1'b0;
        end
      end
      if (upd) begin
        check("upd_expected", 32'(upd_q.size() != 0), 32'd1);
        if (upd_q.size() != 0) check("upd_cycle", 32'(cyc), 32'(upd_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: no finish by cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    value = '0;
    dp_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Slot 0 of a zero display starts at cycle 3; reset lands inside it.
    push_frame(~7'h3F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 1);
    reset_pulse_at(6);

    push_frame(~7'h3F, 7'h7F,  7'h7F,  7'h7F,  4'h0, 4); // 0000 after reset
    push_frame(~7'h71, ~7'h4F, ~7'h77, ~7'h06, 4'h0, 4); // 1A3F
    push_frame(~7'h6D, 7'h7F,  7'h7F,  7'h7F,  4'h2, 4); // 0005, dp on blanked digit 1
    push_frame(~7'h3F, 7'h7F,  7'h7F,  7'h7F,  4'h0, 4); // 0000
    push_frame(~7'h5B, ~7'h5B, ~7'h5B, ~7'h5B, 4'h0, 4); // 2222 (1111 overwritten)
    push_frame(~7'h4F, ~7'h4F, ~7'h4F, ~7'h4F, 4'h0, 3); // 3333 until reset
    upd_q.push_back(32);
    upd_q.push_back(64);
    upd_q.push_back(96);
    upd_q.push_back(128);
    upd_q.push_back(160);

    load_at(10,  16'h1A3F, 4'h0);
    load_at(40,  16'h0005, 4'h2);
    load_at(70,  16'h0000, 4'h0);
    load_at(100, 16'h1111, 4'h0);
    load_at(110, 16'h2222, 4'h0);
    load_at(128, 16'h3333, 4'h0);
    load_at(170, 16'hBEEF, 4'hF);

    // Reset before the boundary that would apply BEEF.
    reset_pulse_at(186);
    check("slots_consumed_pre_reset", 32'(slot_q.size()), 32'd0);

    push_frame(~7'h3F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 4);
    push_frame(~7'h3F, 7'h7F, 7'h7F, 7'h7F, 4'h0, 4);
    while (cyc != 66) @(negedge clk);

    check("slots_consumed", 32'(slot_q.size()), 32'd0);
    check("upds_consumed",  32'(upd_q.size()),  32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
